// File: rtl/sha_digest_axis_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha_digest_axis_tx: captures a final Keccak state and streams the truncated |
// | digest as AXI4-Stream beats. Optional macro: SHA_TX_RAW_STATE_EN.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sha_digest_axis_tx #(
  parameter int WIDTH = 16
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [1599:0]      state_i,
  input  logic               digest_valid_i,
  output logic               digest_ready_o,
  input  logic [1:0]         sha_sel_i,
  input  logic               mode_i,
  output logic               TVALID_o,
  input  logic               TREADY_i,
  output logic [WIDTH-1:0]   TDATA_o,
  output logic               TLAST_o,
  output logic [WIDTH/8-1:0] TKEEP_o,
  output logic [WIDTH/8-1:0] TSTRB_o,
  output logic [1:0]         TUSER_o,
  output logic               TID_o,
  output logic [7:0]         TDEST_o,
  output logic               busy_o
);

  localparam int BYTES = WIDTH / 8;

  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_width_check
    $error("sha_digest_axis_tx: WIDTH must be 8, 16 or 32");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q;
  logic [1599:0]      shreg_q;
  logic [WIDTH-1:0]   tdata_q;
  logic               tvalid_q;
  logic               tlast_q;
  logic [BYTES-1:0]   keep_q;
  logic [1:0]         user_q;
  logic               tid_q;
  logic [7:0]         dest_q;
  logic [7:0]         last_idx_q;
  logic               busy_q;
  logic               ready_q;

  logic [7:0]         last_idx_d;
  logic               tid_d;

  // Lowest-addressed byte of the slice goes to the MSBs of the beat.
  function automatic logic [WIDTH-1:0] order_bytes(input logic [WIDTH-1:0] lsb_first);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) begin
      r[WIDTH-1-8*i -: 8] = lsb_first[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    last_idx_d = '0;
    case (sha_sel_i)
      2'd0:    last_idx_d = 8'(224 / WIDTH - 1);
      2'd1:    last_idx_d = 8'(256 / WIDTH - 1);
      2'd2:    last_idx_d = 8'(384 / WIDTH - 1);
      default: last_idx_d = 8'(512 / WIDTH - 1);
    endcase
`ifdef SHA_TX_RAW_STATE_EN
    if (!mode_i) begin
      last_idx_d = 8'(1600 / WIDTH - 1);
    end
    tid_d = mode_i;
`else
    tid_d = 1'b1;
`endif
  end

`ifndef SHA_TX_RAW_STATE_EN
  logic unused_mode;
  assign unused_mode = mode_i;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      keep_q     <= '0;
      user_q     <= '0;
      tid_q      <= 1'b0;
      dest_q     <= '0;
      last_idx_q <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (digest_valid_i && ready_q) begin
            state_q    <= SEND;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            tvalid_q   <= 1'b1;
            tlast_q    <= 1'b0;
            keep_q     <= '1;
            dest_q     <= '0;
            last_idx_q <= last_idx_d;
            user_q     <= sha_sel_i;
            tid_q      <= tid_d;
            tdata_q    <= order_bytes(state_i[WIDTH-1:0]);
            shreg_q    <= state_i >> WIDTH;
          end
        end
        SEND: begin
          if (tvalid_q && TREADY_i) begin
            if (tlast_q) begin
              state_q  <= IDLE;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              keep_q   <= '0;
              dest_q   <= '0;
              tdata_q  <= '0;
            end else begin
              dest_q  <= dest_q + 8'd1;
              tlast_q <= (dest_q + 8'd1 == last_idx_q);
              tdata_q <= order_bytes(shreg_q[WIDTH-1:0]);
              shreg_q <= shreg_q >> WIDTH;
            end
          end
        end
      endcase
    end
  end

  assign digest_ready_o = ready_q;
  assign TVALID_o       = tvalid_q;
  assign TDATA_o        = tdata_q;
  assign TLAST_o        = tlast_q;
  assign TKEEP_o        = keep_q;
  assign TSTRB_o        = keep_q;
  assign TUSER_o        = user_q;
  assign TID_o          = tid_q;
  assign TDEST_o        = dest_q;
  assign busy_o         = busy_q;

endmodule
`default_nettype wire

// File: doc/sha_digest_axis_tx.md
# sha_digest_axis_tx

Streams the SHA-3 result out of the core as AXI4-Stream. Captures the final 1600-bit Keccak state from the permutation engine in one handshake. Serializes the selected digest, truncated by SHA size, into `WIDTH`-bit beats with `TLAST` on the final beat. It is the output-side counterpart of the core's AXI-Stream message receiver and feeds the digest collector or DMA.

## Interface
- `WIDTH`, default 16: stream data width in bits. Legal values are 8, 16 and 32; any other value is a compile-time error.
- `ACLK` in 1: the single clock.
- `ARESETn` in 1: reset, synchronous and active-low.
- `state_i` in 1600: Keccak state. Lane (x,y) sits at bits `[64*(x+5y)+63 : 64*(x+5y)]`. Digest byte b = `state_i[8b+7:8b]`.
- `digest_valid_i` in 1: `state_i` holds a final state.
- `digest_ready_o` out 1: the block can capture a state.
- `sha_sel_i` in 2: digest size. 0 = 224, 1 = 256, 2 = 384, 3 = 512.
- `mode_i` in 1: 1 = digest, 0 = raw state (only meaningful with `SHA_TX_RAW_STATE_EN`).
- `TVALID_o` out 1: beat valid.
- `TREADY_i` in 1: sink accepts the beat.
- `TDATA_o` out `WIDTH`: beat data.
- `TLAST_o` out 1: final beat of the digest.
- `TKEEP_o` out `WIDTH/8`: byte qualifier.
- `TSTRB_o` out `WIDTH/8`: byte qualifier.
- `TUSER_o` out 2: captured `sha_sel_i`.
- `TID_o` out 1: captured mode (1 = digest).
- `TDEST_o` out 8: beat index within the digest, starting at 0.
- `busy_o` out 1: a transfer is in progress.

## Operation
- FSM states:
  - `IDLE`: `digest_ready_o` = 1.
  - `SEND`: beats are being emitted.
- `IDLE` → `SEND` on `digest_valid_i & digest_ready_o`. At that edge the block registers:
  - `state_i` into the output shift register;
  - `sha_sel_i` and `mode_i`;
  - the beat count N = SHA/WIDTH: 224→14, 256→16, 384→24, 512→32 for WIDTH=16; scale accordingly for other widths.
- Beat k data: bytes k·(WIDTH/8) … k·(WIDTH/8)+WIDTH/8−1, first byte in the MSBs.
  - WIDTH=16: `TDATA_o = {byte 2k, byte 2k+1}`, so concatenating the beats in hex prints the standard digest string.
- A beat completes on `TVALID_o & TREADY_i`. The shift register then advances by WIDTH bits and `TDEST_o` increments.
- `TLAST_o` = 1 exactly when `TDEST_o == N−1` and `TVALID_o` = 1.
- After the last beat is accepted: `SEND` → `IDLE`. `TVALID_o` drops the same edge.
- `TKEEP_o` and `TSTRB_o` are all-ones while `TVALID_o` = 1, and 0 otherwise.
- `busy_o` = (state == `SEND`).
- `digest_valid_i` while in `SEND` is ignored. No capture happens and no overlap with the running transfer occurs.
- `sha_sel_i` and `mode_i` changes after capture do not affect the current transfer.

## Timing
- Reset values, applied on the first edge with `ARESETn` = 0: state `IDLE`; `TVALID_o`, `TLAST_o`, `TKEEP_o`, `TSTRB_o`, `TUSER_o`, `TID_o`, `TDEST_o`, `TDATA_o` and `busy_o` all 0; `digest_ready_o` = 0.
- `digest_ready_o` goes to 1 on the first edge after `ARESETn` returns to 1.
- Latency: with the capture handshake at edge E, `TVALID_o` and the beat-0 data are registered at E, i.e. visible in the cycle after E.
- Each subsequent beat appears on the edge its predecessor is accepted. Throughput is 1 beat per cycle with `TREADY_i` held high.
- Full digest takes N cycles. `digest_ready_o` returns at the edge of the final accept, so the next capture is possible 1 cycle later.
- AXI rule: once `TVALID_o` = 1, `TDATA_o`, `TLAST_o`, `TDEST_o`, `TUSER_o` and `TID_o` stay stable until accepted. `TVALID_o` never drops without an accept, except on reset.
- `TVALID_o` does not depend combinationally on `TREADY_i`. All outputs are registered.
- Reset mid-transfer aborts at once: outputs return to their reset values at the next edge. No `TLAST_o` is emitted. The sink must discard the partial digest.

## Configuration
- `SHA_TX_RAW_STATE_EN` defined:
  - a capture with `mode_i` = 0 streams all 200 state bytes;
  - N = 1600/WIDTH (100 beats at WIDTH=16), `TID_o` = 0;
  - `TUSER_o` still echoes `sha_sel_i`.
- Not defined: `mode_i` is ignored and treated as 1. `TID_o` is always 1. The raw-length counter logic is absent.

## Test plan
- Byte b of `state_i` = b mod 256, `sha_sel_i`=1, `TREADY_i`=1 → 16 beats `0x0001` … `0x1e1f`, `TDEST_o` 0…15, `TLAST_o` only on `0x1e1f`, `digest_ready_o` high 1 cycle later.
- Same state, `sha_sel_i`=0 → 14 beats, last `0x1a1b`. `sha_sel_i`=3 → 32 beats, last `0x3e3f`. `TUSER_o` equals the sel value on every beat.
- 256-bit transfer with `TREADY_i` low for 3 cycles at beat 5 → `TDATA_o` holds `0x0a0b`, `TDEST_o` holds 5, `TVALID_o` stays 1, no beat lost or duplicated.
- `digest_valid_i` pulsed with a different state mid-transfer → ignored, the original digest completes unchanged.
- `ARESETn` low for 1 cycle during beat 7 → all outputs 0 next edge, no `TLAST_o`; after release a new capture streams from beat 0 correctly.
- With `SHA_TX_RAW_STATE_EN`, `mode_i`=0 → 100 beats, last `0xc6c7`, `TID_o`=0. Without the macro, the same stimulus gives 16 beats and `TID_o`=1.
